// File: rtl/param_fifo_pkg.sv
// fifo_pkg: shared sizing helpers and default level constants for the
// parameterised synchronous FIFO (param_fifo) and its storage (fifo_ram).
//
// Contents
//   DEF_WIDTH / DEF_DEPTH      default data width and entry count
//   DEF_AF_MARGIN              almost_full default is DEPTH - DEF_AF_MARGIN
//   DEF_AE_LEVEL               almost_empty default level
//   ptr_w(depth)               pointer width, wraps naturally at depth
//   cnt_w(depth)               occupancy width, must hold 0..depth inclusive
//   fifo_op_e                  per-cycle accepted operation {write, read}
package fifo_pkg;

  localparam int DEF_WIDTH     = 8;
  localparam int DEF_DEPTH     = 1024;
  localparam int DEF_AF_MARGIN = 4;
  localparam int DEF_AE_LEVEL  = 4;

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  // One extra bit so that a completely full FIFO (count == depth) is
  // distinguishable from an empty one.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Encoding is {write accepted, read accepted} so the top can cast the
  // two accept strobes straight into an operation code.
  typedef enum logic [1:0] {
    OP_IDLE  = 2'b00,
    OP_RD    = 2'b01,
    OP_WR    = 2'b10,
    OP_WR_RD = 2'b11
  } fifo_op_e;

endpackage

// File: rtl/param_fifo_if.sv
// param_fifo_if: handshake and status bundle of param_fifo.
//
// Signals
//   wr_en, din                 write request and data        (master -> fifo)
//   rd_en                      read request                  (master -> fifo)
//   dout, rd_valid             registered read data + strobe (fifo -> master)
//   full, empty                occupancy status              (fifo -> master)
//   almost_full, almost_empty  threshold status              (fifo -> master)
//   count                      occupancy 0..DEPTH            (fifo -> master)
//   overflow, underflow        sticky error flags            (fifo -> master)
//
// Modports
//   master  user side driving requests
//   slave   FIFO side
interface param_fifo_if #(
  parameter int WIDTH = fifo_pkg::DEF_WIDTH,
  parameter int DEPTH = fifo_pkg::DEF_DEPTH
);

  logic                               wr_en;
  logic [WIDTH-1:0]                   din;
  logic                               rd_en;
  logic [WIDTH-1:0]                   dout;
  logic                               rd_valid;
  logic                               full;
  logic                               empty;
  logic                               almost_full;
  logic                               almost_empty;
  logic [fifo_pkg::cnt_w(DEPTH)-1:0]  count;
  logic                               overflow;
  logic                               underflow;

  modport master (
    output wr_en, din, rd_en,
    input  dout, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  wr_en, din, rd_en,
    output dout, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

endinterface

// File: rtl/param_fifo_ram.sv
// fifo_ram: DEPTH x WIDTH storage for param_fifo.
//
// Ports
//   clk            rising-edge clock
//   we, waddr,     write port, written at the rising edge when we=1
//   wdata
//   re, raddr      read port; rdata registered at the rising edge when re=1
//   rdata          registered read data, held while re=0
//
// There is no reset: contents and rdata power up undefined. A read and a
// write to the same address in one cycle return the old word, which the
// FIFO relies on when it reads and writes simultaneously while full.
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                      clk,
  input  logic                      we,
  input  logic [ptr_w(DEPTH)-1:0]   waddr,
  input  logic [WIDTH-1:0]          wdata,
  input  logic                      re,
  input  logic [ptr_w(DEPTH)-1:0]   raddr,
  output logic [WIDTH-1:0]          rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/param_fifo.sv
// param_fifo: single-clock synchronous FIFO, DEPTH entries of WIDTH bits,
// read latency 1, no fall-through.
//
// Ports
//   clk   rising-edge clock
//   rst   synchronous active-low reset
//   bus   param_fifo_if.slave (requests in, data/status out)
//
// Parameters
//   WIDTH     data width, 1..64
//   DEPTH     entry count, power of two, >= 4
//   AF_LEVEL  almost_full when count >= AF_LEVEL
//   AE_LEVEL  almost_empty when count <= AE_LEVEL
//
// Pointers, occupancy and flags live here; storage is fifo_ram.
module param_fifo
  import fifo_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AF_LEVEL = DEPTH - DEF_AF_MARGIN,
  parameter int AE_LEVEL = DEF_AE_LEVEL
) (
  input  logic         clk,
  input  logic         rst,
  param_fifo_if.slave  bus
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_AF   = CW'(AF_LEVEL);
  localparam logic [CW-1:0] CNT_AE   = CW'(AE_LEVEL);

  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             full;
  logic             empty;
  logic             wr_acc;
  logic             rd_acc;
  fifo_op_e         op;
  logic             rd_valid_q;
  logic             overflow_q;
  logic             underflow_q;
  logic [WIDTH-1:0] ram_rdata;
  logic [WIDTH-1:0] dout_hold;
  logic [WIDTH-1:0] dout_mux;

  assign full  = (count == CNT_FULL);
  assign empty = (count == '0);

  // A read only needs data present. A write needs room, or a read in the
  // same cycle that frees a slot. An empty FIFO is never made readable by a
  // same-cycle write.
  assign rd_acc = bus.rd_en && !empty;
  assign wr_acc = bus.wr_en && (!full || rd_acc);
  assign op     = fifo_op_e'({wr_acc, rd_acc});

  // Gating with rst keeps the RAM quiet while reset is being applied.
  fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_acc && rst),
    .waddr (wr_ptr),
    .wdata (bus.din),
    .re    (rd_acc && rst),
    .raddr (rd_ptr),
    .rdata (ram_rdata)
  );

  // The RAM read register has no reset, so dout is taken from it only in
  // the cycle following an accepted read; otherwise a resettable copy of the
  // last presented word is shown. Both sources are flops, so dout stays a
  // registered value that is 0 after reset and never undefined.
  assign dout_mux = rd_valid_q ? ram_rdata : dout_hold;

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      rd_valid_q  <= 1'b0;
      dout_hold   <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + PW'(1);
      end

      case (op)
        OP_WR:    count <= count + CW'(1);
        OP_RD:    count <= count - CW'(1);
        OP_IDLE,
        OP_WR_RD: count <= count;
        default:  count <= count;
      endcase

      rd_valid_q <= rd_acc;
      dout_hold  <= dout_mux;

      if (bus.wr_en && full && !rd_acc) begin
        overflow_q <= 1'b1;
      end
      if (bus.rd_en && empty) begin
        underflow_q <= 1'b1;
      end
    end
  end

  assign bus.dout         = dout_mux;
  assign bus.rd_valid     = rd_valid_q;
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (count >= CNT_AF);
  assign bus.almost_empty = (count <= CNT_AE);
  assign bus.count        = count;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

endmodule

// File: doc/param_fifo.md
PARAM_FIFO -- requirements
Module: param_fifo

Interface
REQ-001 Parameter WIDTH, default 8: data word width in bits; legal range 1..64.
REQ-002 Parameter DEPTH, default 1024: number of entries; power of two, at least 4.
REQ-003 Parameter AF_LEVEL, default DEPTH-4: almost_full asserts when count >= AF_LEVEL.
REQ-004 Parameter AE_LEVEL, default 4: almost_empty asserts when count <= AE_LEVEL.
REQ-005 clk  input  1  single clock; all logic on its rising edge.
REQ-006 rst  input  1  reset, synchronous and active-low.
REQ-007 wr_en  input  1  write request.
REQ-008 din  input  WIDTH  write data.
REQ-009 rd_en  input  1  read request.
REQ-010 dout  output  WIDTH  read data, registered.
REQ-011 rd_valid  output  1  dout carries a newly read word this cycle.
REQ-012 full, empty  output  1 each  status flags.
REQ-013 almost_full, almost_empty  output  1 each  threshold flags.
REQ-014 count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-015 overflow, underflow  output  1 each  sticky error flags.

Function
REQ-016 The FIFO shall hold exactly DEPTH entries; full = (count == DEPTH), empty = (count == 0), both combinational from count.
REQ-017 A write is accepted when wr_en=1 and (full=0 or a read is accepted in the same cycle); the word is stored at wr_ptr.
REQ-018 A read is accepted when rd_en=1 and empty=0; a write in the same cycle never makes an empty FIFO readable (no fall-through).
REQ-019 On an accepted read, dout shall take mem[rd_ptr] at the next rising edge and rd_valid shall be 1 for exactly that cycle (read latency 1).
REQ-020 Without an accepted read, dout shall hold its last value (never X or Z) and rd_valid shall be 0.
REQ-021 wr_ptr and rd_ptr are $clog2(DEPTH) bits wide and wrap from DEPTH-1 to 0 by natural overflow.
REQ-022 count shall update as +1 for a write only, -1 for a read only, and stay unchanged for both or neither.
REQ-023 almost_full and almost_empty shall be combinational compares of count against AF_LEVEL and AE_LEVEL.
REQ-024 A write request while full with no accepted read shall set overflow; the data is dropped and the state is unchanged.
REQ-025 A read request while empty shall set underflow; dout, rd_valid and the pointers are unchanged.
REQ-026 overflow and underflow clear only on reset.
REQ-027 Storage contents are not cleared on read.

Reset
REQ-028 When rst=0 at a rising edge, wr_ptr, rd_ptr and count shall become 0.
REQ-029 Reset shall also clear dout, rd_valid, overflow and underflow to 0.
REQ-030 Storage is not reset; it is unreadable until rewritten because empty=1 after reset.
REQ-031 Reset asserted mid-operation shall discard all contents in one cycle and override any same-cycle wr_en or rd_en.
REQ-032 The first operation is accepted at the first rising edge with rst=1.

Structure
REQ-033 Package fifo_pkg shall hold the pointer-width and count-width helper functions and the default level constants.
REQ-034 Storage shall be a sub-module fifo_ram: 1 write port and 1 registered read port, parameterised by WIDTH and DEPTH, with no reset.
REQ-035 Pointer, count and flag logic shall reside in param_fifo; the target size is 120-400 lines of RTL.

Verification (WIDTH=8, DEPTH=16, AF_LEVEL=12, AE_LEVEL=4)
REQ-036 Reset, then write 0x01..0x10 (16 words) -> full=1 and count=16; almost_full is set from count=12; 16 reads return 0x01..0x10 in order, each with rd_valid=1 one cycle after rd_en, then empty=1.
REQ-037 Write 0xAA while full -> overflow=1 and count stays 16; a later read returns 0x01, not 0xAA.
REQ-038 Simultaneous wr_en and rd_en while full with din=0x55 -> count stays 16, dout=0x01, and 0x55 is read last.
REQ-039 rd_en while empty, with or without same-cycle wr_en=0x77 -> underflow=1, rd_valid=0; count=1 after the write, and the next read returns 0x77.
REQ-040 Run 40 writes/reads at a steady fill of 3-5 words so both pointers wrap twice -> data order is preserved and almost_empty toggles at count 4/5.
REQ-041 Assert rst=0 for one cycle at count=9 with wr_en=1 -> next cycle count=0, empty=1, overflow=0, and dout=0.
